power_switch_sequencer: RTL and testbench
=========================================

Name: power_switch_sequencer

Overview:
- Power-domain switch sequencer driven by the enable_req/enable_ack pair of the power control node, sitting directly downstream of it.
- Four-phase handshake target. Power-up order: staged switch turn-on, wait for switch chain ack, release isolation, release domain reset, enable domain clock, then assert enable_ack.
- Power-down runs the exact reverse order; enable_ack falls only when the domain is fully off.

Parameters:
- STAGES, 4, number of daisy-chained switch groups (>=1); width of switch_enable.
- STAGE_DELAY, 8, cycles between successive stage toggles, and the tail wait after the last toggle (>=1).
- ISO_DELAY, 2, cycles isolate holds its new value before the next step (>=1).
- RESET_DELAY, 4, cycles domain_reset holds before the next step (>=1).
- CLK_DELAY, 2, cycles clock_enable holds before the next step (>=1).
- SWITCH_TIMEOUT, 1024, cycles in a wait state before timeout_error sets (>=1).

Ports:
- clock  in  1  single block clock
- async_reset  in  1  asynchronous, active-high reset
- enable_req  in  1  power request from control node
- enable_ack  out  1  domain-on acknowledge
- switch_enable  out  STAGES  switch group enables, thermometer coded, bit0 first on
- switch_ack  in  1  asynchronous ack from end of switch chain
- isolate  out  1  domain output isolation, 1 = clamped
- domain_reset  out  1  domain reset, active high
- clock_enable  out  1  domain clock gate enable
- busy  out  1  sequence in progress
- timeout_error  out  1  sticky switch ack timeout

Behaviour:
- Reset (asynchronous, any time, including mid-sequence): state OFF, enable_ack=0, switch_enable=0, isolate=1, domain_reset=1, clock_enable=0, busy=0, timeout_error=0, counters=0, synchronizer flops=0.
- switch_ack passes through a 2-flop synchronizer; all decisions use the synchronized value ack_s.
- States: OFF, SW_ON, WAIT_ON, ISO_REL, RST_REL, CLK_ON, ON, CLK_OFF, ISO_SET, RST_SET, SW_OFF, WAIT_OFF.
- OFF -> SW_ON when enable_req=1. The entry edge sets switch_enable[0]. Each further STAGE_DELAY cycles sets the next bit. STAGE_DELAY cycles after the top bit is set -> WAIT_ON.
- WAIT_ON -> ISO_REL when ack_s=1. The entry edge sets isolate=0; held ISO_DELAY cycles -> RST_REL.
- RST_REL: entry edge sets domain_reset=0; held RESET_DELAY cycles -> CLK_ON.
- CLK_ON: entry edge sets clock_enable=1; held CLK_DELAY cycles -> ON.
- ON: entry edge sets enable_ack=1. Stays in ON while enable_req=1.
- ON -> CLK_OFF when enable_req=0. Entry edge sets clock_enable=0; CLK_DELAY -> ISO_SET (isolate=1; ISO_DELAY) -> RST_SET (domain_reset=1; RESET_DELAY) -> SW_OFF.
- SW_OFF: entry edge clears the top bit; each STAGE_DELAY cycles clears the next lower bit. STAGE_DELAY after bit0 clears -> WAIT_OFF.
- WAIT_OFF -> OFF when ack_s=0. The entry edge into OFF sets enable_ack=0.
- Strict four-phase, no abort:
  - enable_req falling during power-up: power-up completes to ON, ack rises, then power-down starts the next cycle.
  - enable_req rising during power-down: power-down completes to OFF, ack falls, then power-up starts the next cycle.
- enable_ack is 0 in OFF and all power-up states, and 1 in ON and all power-down states.
- busy=1 in every state except OFF and ON (registered, same edge as the state change).
- Timeout: the counter runs in WAIT_ON/WAIT_OFF. Reaching SWITCH_TIMEOUT sets timeout_error, which stays set until reset. The FSM keeps waiting; no forced advance.
- STAGES=1: a single toggle, then the tail wait.
- Counter width: clog2 of the maximum of all delay and timeout parameters.

Decomposition:
- Package power_pkg: state enum typedef power_seq_state_t, and a localparam function for counter width.
- Sub-module power_logic_sync_2ff (clock, async_reset, data_in, data_out) for switch_ack.
- The FSM, stage counter, delay counter and timeout counter live in the top module.

Test Plan:
- Reset release with enable_req=0 -> outputs stay at reset values: isolate=1, domain_reset=1, switch_enable=0, enable_ack=0, busy=0.
- Power-up: defaults, enable_req=1, bench drives switch_ack = switch_enable[3] delayed 5 cycles. Required response:
  - switch_enable steps 0001/0011/0111/1111 exactly 8 cycles apart.
  - isolate falls only after switch_ack plus synchronizer delay.
  - domain_reset falls exactly 2 cycles after isolate.
  - clock_enable rises exactly 4 cycles after domain_reset.
  - enable_ack rises exactly 2 cycles after clock_enable.
- Power-down from ON: enable_req=0 -> required response:
  - clock_enable falls first; isolate=1 after 2 cycles; domain_reset=1 after 2 more cycles; after 4 more cycles switch_enable begins clearing.
  - switch_enable steps 0111/0011/0001/0000 exactly 8 cycles apart.
  - enable_ack falls only after switch_ack low is synchronized.
- Request drop 3 cycles into SW_ON -> full power-up still completes (enable_ack=1 for at least one cycle), then the full power-down follows; no reordering.
- switch_ack held 0 in WAIT_ON -> timeout_error=1 after 1024 cycles, isolate stays 1. Later switch_ack=1 -> sequence completes and timeout_error stays 1.
- async_reset pulsed mid-ISO_REL -> immediate reset values on the same cycle, with no clock edge needed; next enable_req restarts from stage 0.

Source files
------------

// File: rtl/power_pkg.sv
// Shared types and helpers for the power-domain switch sequencer.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package power_pkg;

    // Power-up runs top to bottom through ON; power-down continues in reverse order.
    typedef enum logic [3:0] {
        OFF,
        SW_ON,
        WAIT_ON,
        ISO_REL,
        RST_REL,
        CLK_ON,
        ON,
        CLK_OFF,
        ISO_SET,
        RST_SET,
        SW_OFF,
        WAIT_OFF
    } power_seq_state_t;

    // The counters only ever count up to (parameter - 1), so clog2 of the
    // largest parameter is enough. Floor at one bit for the all-ones case.
    function automatic int cnt_width(input int a, input int b, input int c,
                                     input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/power_logic_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Latency: data_out follows data_in after two clock edges.
// Backpressure: none; a plain level is passed through.
// Ports: clock, async_reset (active high), data_in (async), data_out (synchronized).
module power_logic_sync_2ff (
    input  logic clock,
    input  logic async_reset,
    input  logic data_in,
    output logic data_out
);

    logic meta;

    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            meta     <= 1'b0;
            data_out <= 1'b0;
        end else begin
            meta     <= data_in;
            data_out <= meta;
        end
    end

endmodule

// File: rtl/power_switch_sequencer.sv
// Power-domain switch sequencer: staged switch on, isolation/reset/clock release, and the reverse.
// Latency: every output is registered and changes on the edge that enters the owning state.
// Backpressure: strict four-phase on enable_req/enable_ack; a request change mid-sequence waits for completion.
// Ports: clock, async_reset (active high); enable_req/enable_ack handshake with the control node;
//        switch_enable (thermometer, bit0 first) and switch_ack from the switch chain;
//        isolate, domain_reset, clock_enable to the domain; busy and sticky timeout_error status.
module power_switch_sequencer
    import power_pkg::*;
#(
    parameter int STAGES         = 4,
    parameter int STAGE_DELAY    = 8,
    parameter int ISO_DELAY      = 2,
    parameter int RESET_DELAY    = 4,
    parameter int CLK_DELAY      = 2,
    parameter int SWITCH_TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              async_reset,
    input  logic              enable_req,
    output logic              enable_ack,
    output logic [STAGES-1:0] switch_enable,
    input  logic              switch_ack,
    output logic              isolate,
    output logic              domain_reset,
    output logic              clock_enable,
    output logic              busy,
    output logic              timeout_error
);

    localparam int CW  = cnt_width(STAGE_DELAY, ISO_DELAY, RESET_DELAY,
                                   CLK_DELAY, SWITCH_TIMEOUT);
    localparam int SGW = (STAGES > 1) ? $clog2(STAGES) : 1;

    localparam logic [CW-1:0]  STG_LAST  = CW'(STAGE_DELAY - 1);
    localparam logic [CW-1:0]  ISO_LAST  = CW'(ISO_DELAY - 1);
    localparam logic [CW-1:0]  RST_LAST  = CW'(RESET_DELAY - 1);
    localparam logic [CW-1:0]  CLK_LAST  = CW'(CLK_DELAY - 1);
    localparam logic [CW-1:0]  TO_LAST   = CW'(SWITCH_TIMEOUT - 1);
    localparam logic [SGW-1:0] STAGE_TOP = SGW'(STAGES - 1);

    power_seq_state_t  state, state_nxt;
    logic [CW-1:0]     dcnt, dcnt_nxt;
    logic [CW-1:0]     tcnt, tcnt_nxt;
    logic [SGW-1:0]    stage, stage_nxt;
    logic [STAGES-1:0] sw_nxt;
    logic              terr_nxt;
    logic              ack_s;

    logic ack_nxt, iso_nxt, drst_nxt, clken_nxt, busy_nxt;

    power_logic_sync_2ff u_ack_sync (
        .clock       (clock),
        .async_reset (async_reset),
        .data_in     (switch_ack),
        .data_out    (ack_s)
    );

    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            state         <= OFF;
            dcnt          <= '0;
            tcnt          <= '0;
            stage         <= '0;
            switch_enable <= '0;
            timeout_error <= 1'b0;
            enable_ack    <= 1'b0;
            isolate       <= 1'b1;
            domain_reset  <= 1'b1;
            clock_enable  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            dcnt          <= dcnt_nxt;
            tcnt          <= tcnt_nxt;
            stage         <= stage_nxt;
            switch_enable <= sw_nxt;
            timeout_error <= terr_nxt;
            enable_ack    <= ack_nxt;
            isolate       <= iso_nxt;
            domain_reset  <= drst_nxt;
            clock_enable  <= clken_nxt;
            busy          <= busy_nxt;
        end
    end

    // Next state and counters. dcnt is cleared on every state change and
    // every stage toggle, so each hold starts counting from the entry edge.
    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt + 1'b1;
        tcnt_nxt  = tcnt;
        stage_nxt = stage;
        sw_nxt    = switch_enable;
        terr_nxt  = timeout_error;

        unique case (state)
            OFF: begin
                dcnt_nxt = '0;
                if (enable_req) begin
                    state_nxt = SW_ON;
                    stage_nxt = '0;
                    sw_nxt    = STAGES'(1);
                end
            end
            SW_ON: begin
                if (dcnt == STG_LAST) begin
                    dcnt_nxt = '0;
                    if (stage == STAGE_TOP) begin
                        state_nxt = WAIT_ON;
                        tcnt_nxt  = '0;
                    end else begin
                        stage_nxt = stage + 1'b1;
                        sw_nxt    = (switch_enable << 1) | STAGES'(1);
                    end
                end
            end
            WAIT_ON, WAIT_OFF: begin
                dcnt_nxt = '0;
                // Timeout only flags; the sequencer keeps waiting for the chain.
                if (tcnt == TO_LAST) begin
                    terr_nxt = 1'b1;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
                if (state == WAIT_ON && ack_s) begin
                    state_nxt = ISO_REL;
                end else if (state == WAIT_OFF && !ack_s) begin
                    state_nxt = OFF;
                end
            end
            ISO_REL: begin
                if (dcnt == ISO_LAST) begin
                    state_nxt = RST_REL;
                    dcnt_nxt  = '0;
                end
            end
            RST_REL: begin
                if (dcnt == RST_LAST) begin
                    state_nxt = CLK_ON;
                    dcnt_nxt  = '0;
                end
            end
            CLK_ON: begin
                if (dcnt == CLK_LAST) begin
                    state_nxt = ON;
                    dcnt_nxt  = '0;
                end
            end
            ON: begin
                dcnt_nxt = '0;
                if (!enable_req) begin
                    state_nxt = CLK_OFF;
                end
            end
            CLK_OFF: begin
                if (dcnt == CLK_LAST) begin
                    state_nxt = ISO_SET;
                    dcnt_nxt  = '0;
                end
            end
            ISO_SET: begin
                if (dcnt == ISO_LAST) begin
                    state_nxt = RST_SET;
                    dcnt_nxt  = '0;
                end
            end
            RST_SET: begin
                if (dcnt == RST_LAST) begin
                    // Entry into SW_OFF drops the top group immediately.
                    state_nxt = SW_OFF;
                    dcnt_nxt  = '0;
                    stage_nxt = STAGE_TOP;
                    sw_nxt    = switch_enable >> 1;
                end
            end
            SW_OFF: begin
                if (dcnt == STG_LAST) begin
                    dcnt_nxt = '0;
                    if (stage == '0) begin
                        state_nxt = WAIT_OFF;
                        tcnt_nxt  = '0;
                    end else begin
                        stage_nxt = stage - 1'b1;
                        sw_nxt    = switch_enable >> 1;
                    end
                end
            end
            default: begin
                state_nxt = OFF;
                dcnt_nxt  = '0;
            end
        endcase
    end

    // Domain controls are a pure decode of the state being entered, which
    // makes each one change on exactly the entry edge of its step.
    always_comb begin
        ack_nxt   = state_nxt inside {ON, CLK_OFF, ISO_SET, RST_SET, SW_OFF, WAIT_OFF};
        iso_nxt   = !(state_nxt inside {ISO_REL, RST_REL, CLK_ON, ON, CLK_OFF});
        drst_nxt  = !(state_nxt inside {RST_REL, CLK_ON, ON, CLK_OFF, ISO_SET});
        clken_nxt = state_nxt inside {CLK_ON, ON};
        busy_nxt  = !(state_nxt inside {OFF, ON});
    end

endmodule

// File: tb/tb_power_switch_sequencer.sv
// Self-checking bench: each handshake sequence is turned into a timeline of
// expected output transitions, and the DUT is compared on every cycle where
// either the expected or the observed output vector changes.
module tb_power_switch_sequencer;

    localparam int S  = 4;
    localparam int SD = 8;
    localparam int ID = 2;
    localparam int RD = 4;
    localparam int CD = 2;
    localparam int TO = 1024;
    localparam int NV = S + 6;

    // Vector layout: [S-1:0] switch_enable, S isolate, S+1 domain_reset,
    // S+2 clock_enable, S+3 timeout_error, S+4 busy, S+5 enable_ack.
    localparam int B_ISO  = S;
    localparam int B_DRST = S + 1;
    localparam int B_CLK  = S + 2;
    localparam int B_TO   = S + 3;
    localparam int B_BUSY = S + 4;
    localparam int B_ACK  = S + 5;
    localparam logic [NV-1:0] RST_V = NV'(3) << S;

    logic          clock = 1'b0;
    logic          async_reset;
    logic          enable_req;
    logic          switch_ack;
    logic          enable_ack;
    logic [S-1:0]  switch_enable;
    logic          isolate;
    logic          domain_reset;
    logic          clock_enable;
    logic          busy;
    logic          timeout_error;

    power_switch_sequencer #(
        .STAGES         (S),
        .STAGE_DELAY    (SD),
        .ISO_DELAY      (ID),
        .RESET_DELAY    (RD),
        .CLK_DELAY      (CD),
        .SWITCH_TIMEOUT (TO)
    ) dut (
        .clock         (clock),
        .async_reset   (async_reset),
        .enable_req    (enable_req),
        .enable_ack    (enable_ack),
        .switch_enable (switch_enable),
        .switch_ack    (switch_ack),
        .isolate       (isolate),
        .domain_reset  (domain_reset),
        .clock_enable  (clock_enable),
        .busy          (busy),
        .timeout_error (timeout_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int   cyc;
        int   idx;
        logic val;
    } ev_t;

    ev_t           evq[$];   // expected output transitions
    ev_t           stq[$];   // stimulus: idx 0 = enable_req, 1 = switch_ack
    int            cyc;
    int            checks;
    int            errors;
    int            last_off;
    int            last_drop;
    int            p_iso;
    logic [NV-1:0] exp_v;
    logic [NV-1:0] prev_dv;
    string         tag;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [NV-1:0] dut_vec();
        return {enable_ack, busy, timeout_error, clock_enable, domain_reset,
                isolate, switch_enable};
    endfunction

    function automatic void ev(input int c, input int i, input logic v);
        evq.push_back('{cyc: c, idx: i, val: v});
    endfunction

    function automatic void st(input int c, input int i, input logic v);
        stq.push_back('{cyc: c, idx: i, val: v});
    endfunction

    task automatic check(input string t);
        logic [NV-1:0] dv;
        dv = dut_vec();
        checks++;
        assert (dv === exp_v)
        else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", t, cyc, dv, exp_v);
        end
    endtask

    // One clock: advance, apply due expected transitions, compare on change,
    // then drive stimulus scheduled for this negedge.
    task automatic tick();
        logic          chg;
        logic [NV-1:0] dv;
        @(posedge clock);
        cyc++;
        @(negedge clock);
        chg = 1'b0;
        for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].cyc <= cyc) begin
                exp_v[evq[i].idx] = evq[i].val;
                evq.delete(i);
                chg = 1'b1;
            end
        end
        dv = dut_vec();
        if (chg || dv !== prev_dv) check(tag);
        prev_dv = dv;
        for (int i = stq.size() - 1; i >= 0; i--) begin
            if (stq[i].cyc <= cyc) begin
                if (stq[i].idx == 0) enable_req = stq[i].val;
                else                 switch_ack = stq[i].val;
                stq.delete(i);
            end
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    // Builds the full up/down timeline for one request pulse.
    //   r      : negedge at which enable_req rises
    //   lat_up : cycles after the top switch group turns on until the chain acks
    //   early  : >0 drops enable_req that many cycles after power-up starts
    //   hold   : otherwise, cycles enable_req stays high after enable_ack rises
    //   lat_dn : cycles after bit0 turns off until the chain ack falls
    task automatic plan(input int r, input int lat_up, input int early,
                        input int hold, input int lat_dn);
        int s, top, w, a, iso, on, dd, c, p0, b0, w2, a2, off;
        s = imax(r, last_off) + 1;
        ev(s, B_BUSY, 1'b1);
        for (int i = 0; i < S; i++) ev(s + i * SD, i, 1'b1);
        top = s + (S - 1) * SD;
        w   = s + S * SD;
        a   = top + lat_up;
        iso = imax(w, a + 2) + 1;           // two sync flops, then one decision edge
        if (iso >= w + TO) ev(w + TO, B_TO, 1'b1);
        ev(iso, B_ISO, 1'b0);
        ev(iso + ID, B_DRST, 1'b0);
        ev(iso + ID + RD, B_CLK, 1'b1);
        on = iso + ID + RD + CD;
        ev(on, B_ACK, 1'b1);
        ev(on, B_BUSY, 1'b0);
        dd = (early > 0) ? s + early : on + hold;
        c  = imax(on, dd) + 1;
        ev(c, B_CLK, 1'b0);
        ev(c, B_BUSY, 1'b1);
        ev(c + CD, B_ISO, 1'b1);
        ev(c + CD + ID, B_DRST, 1'b1);
        p0 = c + CD + ID + RD;
        for (int j = 0; j < S; j++) ev(p0 + j * SD, S - 1 - j, 1'b0);
        b0  = p0 + (S - 1) * SD;
        w2  = p0 + S * SD;
        a2  = b0 + lat_dn;
        off = imax(w2, a2 + 2) + 1;
        if (off >= w2 + TO) ev(w2 + TO, B_TO, 1'b1);
        ev(off, B_ACK, 1'b0);
        ev(off, B_BUSY, 1'b0);
        st(r, 0, 1'b1);
        st(dd, 0, 1'b0);
        st(a, 1, 1'b1);
        st(a2, 1, 1'b0);
        last_off  = off;
        last_drop = dd;
        p_iso     = iso;
    endtask

    initial begin
        bit ovl;
        int r, lu, ld, early, hold;
        cyc         = 0;
        checks      = 0;
        errors      = 0;
        last_off    = 0;
        last_drop   = 0;
        p_iso       = 0;
        ovl         = 1'b0;
        tag         = "reset";
        async_reset = 1'b1;
        enable_req  = 1'b0;
        switch_ack  = 1'b0;
        exp_v       = RST_V;
        prev_dv     = 'x;
        #1;
        check("reset_assert");
        repeat (3) tick();
        async_reset = 1'b0;
        last_off    = cyc;
        tag         = "reset_idle";
        repeat (6) tick();
        check("reset_idle_end");

        tag = "nominal";
        plan(cyc + 1, 5, 0, 10, 5);
        run_to(last_off + 2);
        check("nominal_end");

        tag = "early_drop";
        plan(cyc + 1, 5, 3, 0, 5);
        run_to(last_off + 2);
        check("early_drop_end");

        for (int k = 0; k < 8; k++) begin
            tag = "random";
            if (ovl) r = imax(last_drop + 1, last_off - int'($urandom_range(1, 12)));
            else     r = cyc + 1 + int'($urandom_range(0, 5));
            lu = int'($urandom_range(0, 12));
            ld = int'($urandom_range(0, 12));
            if ($urandom_range(0, 1) == 1) begin
                early = int'($urandom_range(1, S * SD + 10));
                hold  = 0;
            end else begin
                early = 0;
                hold  = int'($urandom_range(0, 8));
            end
            plan(r, lu, early, hold, ld);
            ovl = ($urandom_range(0, 1) == 1);
            if (!ovl) run_to(last_off + 2);
        end
        run_to(last_off + 2);
        check("random_end");

        tag = "timeout";
        plan(cyc + 1, 1100, 0, 4, 3);
        run_to(last_off + 2);
        check("timeout_end");

        tag = "after_timeout";
        plan(cyc + 1, 2, 0, 3, 2);
        run_to(last_off + 2);
        check("after_timeout_end");

        tag = "reset_mid_iso";
        plan(cyc + 1, 4, 0, 6, 4);
        run_to(p_iso);
        #2;
        async_reset = 1'b1;
        #1;
        exp_v = RST_V;
        check("async_reset_mid_iso");
        evq.delete();
        stq.delete();
        enable_req = 1'b0;
        switch_ack = 1'b0;
        #1;
        async_reset = 1'b0;
        last_off    = cyc;
        prev_dv     = dut_vec();
        tag         = "post_reset_idle";
        repeat (4) tick();
        check("post_reset_idle_end");

        tag = "restart";
        plan(cyc + 1, 3, 0, 5, 3);
        run_to(last_off + 2);
        check("restart_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
